fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DEPTH, default 4: FIFO entries and the maximum number of in-flight requests; power of 2, >=2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  out  1  instruction-memory read request valid.
REQ-007 req_ready  in  1  memory accepts the request this cycle.
REQ-008 req_addr  out  32  word-aligned fetch address.
REQ-009 rsp_valid  in  1  read data valid; responses arrive in request order, at least 1 cycle after acceptance.
REQ-010 rsp_data  in  32  instruction word.
REQ-011 redirect  in  1  flush the queue and restart fetch (taken branch, jal, jalr).
REQ-012 redirect_pc  in  32  new fetch address; bit[1:0] ignored, forced to 0.
REQ-013 out_valid  out  1  head entry available to the execute stage.
REQ-014 out_ready  in  1  execute stage consumes the head this cycle.
REQ-015 out_inst  out  32  head instruction word.
REQ-016 out_pc  out  32  address of out_inst.

Function
REQ-017 The block SHALL hold fetch_pc, rsp_pc, inflight (0..DEPTH), count (0..DEPTH), drop (0..DEPTH) and state {RUN, DRAIN}.
REQ-018 In RUN, req_valid SHALL equal (inflight+count < DEPTH) && !redirect, with req_addr = fetch_pc.
REQ-019 On req_valid&&req_ready, fetch_pc SHALL advance by 4 (mod 2^32) and inflight SHALL increment.
REQ-020 In RUN, each rsp_valid SHALL push {rsp_pc, rsp_data}, advance rsp_pc by 4, and decrement inflight.
REQ-021 A pushed entry SHALL first be visible on out_valid in the cycle after rsp_valid (1-cycle latency).
REQ-022 out_valid SHALL equal count!=0; out_inst/out_pc SHALL show the head entry, and SHALL be 0 when count==0.
REQ-023 out_valid&&out_ready SHALL pop the head; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-024 Credit rule: the FIFO SHALL never overflow; a pop in the current cycle SHALL NOT grant credit until the next cycle.
REQ-025 On redirect, the block SHALL clear the FIFO, ignore any same-cycle pop or push, and load fetch_pc=rsp_pc={redirect_pc[31:2],2'b00}.
REQ-026 On redirect, drop SHALL be loaded with inflight minus any same-cycle rsp_valid, and inflight SHALL be loaded with the same value.
REQ-027 After a redirect, the block SHALL enter DRAIN if the new drop is nonzero and RUN otherwise.
REQ-028 In DRAIN, req_valid SHALL be 0 and out_valid SHALL be 0.
REQ-029 In DRAIN, each rsp_valid SHALL be discarded, decrementing drop and inflight; at drop==1 with rsp_valid, the next state SHALL be RUN.
REQ-030 A redirect during DRAIN SHALL update fetch_pc/rsp_pc and recompute drop per REQ-026.

Reset
REQ-031 While rst=1, the block SHALL set state=RUN, fetch_pc=rsp_pc=RESET_PC, and inflight=count=drop=0.
REQ-032 While rst=1, the block SHALL drive req_valid=0, out_valid=0, out_inst=0 and out_pc=0; req_addr SHALL equal RESET_PC.
REQ-033 Reset mid-operation SHALL abandon in-flight requests without drop tracking; the memory is reset alongside.
REQ-034 In the first cycle after rst falls, req_valid SHALL be 1 with req_addr=RESET_PC.

Configuration
REQ-035 The macro FETCH_QUEUE_BYPASS_EN SHALL select the bypass path.
REQ-036 When FETCH_QUEUE_BYPASS_EN is defined, in RUN with count==0 and no redirect, rsp_valid SHALL drive out_valid the same cycle, with out_inst=rsp_data and out_pc=rsp_pc.
REQ-037 With bypass active, if out_ready=1 the response SHALL NOT be pushed; otherwise it SHALL be pushed normally.
REQ-038 When FETCH_QUEUE_BYPASS_EN is undefined, the block SHALL have no combinational path from rsp_* to out_*, and the latency SHALL be exactly per REQ-021.

Verification
REQ-039 Bench: release reset; memory latency 1; out_ready=1 -> out_pc sequence 0x0,0x4,0x8,... with one entry per cycle in steady state.
REQ-040 Bench: out_ready=0 for 20 cycles -> count=4, inflight=0, req_valid=0, and no request beyond 0xC is issued; out_ready=1 -> in-order drain.
REQ-041 Bench: memory latency 3; 3 requests in flight; redirect to 0x100 -> next 3 responses dropped; first out_pc=0x100; no stale entry visible.
REQ-042 Bench: redirect in the same cycle as rsp_valid and out_valid&&out_ready -> response discarded and drop=inflight-1; FIFO empty next cycle.
REQ-043 Bench: redirect_pc=0x203 -> req_addr=0x200.
REQ-044 Bench: FETCH_QUEUE_BYPASS_EN defined, empty FIFO, rsp_valid with rsp_data=0x00500093 -> out_valid=1 and out_inst=0x00500093 the same cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue with credit-limited requests and redirect flush
//
// Issues word-aligned instruction-memory reads, buffers the in-order responses
// in a DEPTH-entry FIFO and presents them to the execute stage. A redirect
// flushes the FIFO and restarts fetch; responses still owed by memory for the
// abandoned path are counted out in the DRAIN state before fetch resumes.
//
// Build option: define FETCH_QUEUE_BYPASS_EN to let a response reach out_* in
// the same cycle when the FIFO is empty. Undefined (default) gives a fully
// registered path from rsp_* to out_* with one cycle of latency.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req_valid/ready   instruction-memory read handshake
//   req_addr          fetch address (word aligned)
//   rsp_valid/data    in-order read data from memory
//   redirect/_pc      flush and restart fetch at redirect_pc (low bits ignored)
//   out_valid/ready   head-entry handshake to the execute stage
//   out_inst, out_pc  head instruction word and its address (0 when empty)
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] count;
    logic [CW-1:0] drop;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];

    logic          run;
    logic          fifo_valid;
    logic          bypass;
    logic          accept;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;
    logic [CW-1:0] inflight_left;
    logic [31:0]   redirect_aligned;

    assign run = !rst && state == RUN;

    // Every accepted request owns a FIFO slot until its entry is popped, so
    // inflight+count never exceeds DEPTH. Using the registered count means a
    // pop only frees credit from the following cycle.
    assign credit_used = {1'b0, inflight} + {1'b0, count};
    assign req_valid   = run && !redirect && credit_used < (CW + 1)'(DEPTH);
    assign req_addr    = rst ? RESET_PC : fetch_pc;
    assign accept      = req_valid && req_ready;

    assign fifo_valid = run && count != '0;
`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = run && !redirect && count == '0 && rsp_valid;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = fifo_valid || bypass;
    assign out_inst  = fifo_valid ? mem_inst[head] : bypass ? rsp_data : '0;
    assign out_pc    = fifo_valid ? mem_pc[head]   : bypass ? rsp_pc   : '0;

    // A bypassed response consumed immediately never enters the FIFO.
    assign push = run && !redirect && rsp_valid && !(bypass && out_ready);
    assign pop  = fifo_valid && !redirect && out_ready;

    // Responses arriving together with a redirect belong to the old path and
    // are simply not counted as still owed.
    assign inflight_left    = inflight - CW'(rsp_valid);
    assign redirect_aligned = redirect_pc & ~32'h3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            count    <= '0;
            drop     <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_aligned;
            rsp_pc   <= redirect_aligned;
            inflight <= inflight_left;
            drop     <= inflight_left;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            state    <= inflight_left != '0 ? DRAIN : RUN;
        end else if (state == DRAIN) begin
            inflight <= inflight_left;
            drop     <= drop - CW'(rsp_valid);
            if (rsp_valid && drop == CW'(1))
                state <= RUN;
        end else begin
            if (accept)
                fetch_pc <= fetch_pc + 32'd4;
            if (rsp_valid)
                rsp_pc <= rsp_pc + 32'd4;
            inflight <= inflight_left + CW'(accept);
            if (push)
                tail <= tail + AW'(1);
            if (pop)
                head <= head + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[tail]   <= rsp_pc;
            mem_inst[tail] <= rsp_data;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scoreboard bench for fetch_queue with an in-order memory model
module tb_fetch_queue;
    localparam logic [31:0] RPC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    fetch_queue #(.DEPTH(4), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    mreq_t       mq[$];
    ent_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          epoch = 0;
    int          rdy_lim = 99;
    int          pops = 0;
    bit          mem_stall = 0;
    bit          mark = 0;
    bit          chk_first = 0;
    bit          last_rsp = 0;
    bit          last_ov = 0;
    logic [31:0] last_inst = '0;
    logic [31:0] exp_fetch = RPC;
    logic [31:0] first_pc = '0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h0050_0093;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        mreq_t r;
        ent_t  e;
        bit    fresh;
        bit    exp_ov;
        int    stale;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_data  = '0;
        fresh     = 1'b0;
        req_ready = mq.size() < rdy_lim;
        if (!rst && !mem_stall && mq.size() > 0 && mq[0].due <= cyc) begin
            r         = mq.pop_front();
            rsp_valid = 1'b1;
            rsp_data  = mdata(r.addr);
            fresh     = r.ep == epoch;
        end
        #1;
        last_rsp  = rsp_valid;
        last_ov   = out_valid;
        last_inst = out_inst;
        if (rst) begin
            chk("rst_req_valid", 32'(req_valid), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_inst", out_inst, 32'd0);
            chk("rst_out_pc", out_pc, 32'd0);
            chk("rst_req_addr", req_addr, RPC);
            mq.delete();
            sb.delete();
            exp_fetch = RPC;
            epoch++;
        end else begin
            if (chk_first) begin
                chk("first_req_valid", 32'(req_valid), 32'd1);
                chk("first_req_addr", req_addr, RPC);
                chk_first = 0;
            end
            exp_ov = sb.size() > 0;
`ifdef FETCH_QUEUE_BYPASS_EN
            if (sb.size() == 0 && rsp_valid && fresh && !redirect)
                exp_ov = 1;
`endif
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            if (redirect) begin
                sb.delete();
                epoch++;
                exp_fetch = redirect_pc & ~32'h3;
                fresh = 0;
            end
            if (rsp_valid && fresh)
                sb.push_back('{r.addr, mdata(r.addr)});
            if (out_valid && out_ready && !redirect) begin
                chk("pop_has_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_inst", out_inst, e.inst);
                end
                pops++;
                if (mark) begin
                    first_pc = out_pc;
                    mark = 0;
                end
            end
            if (!out_valid) begin
                chk("idle_out_inst", out_inst, 32'd0);
                chk("idle_out_pc", out_pc, 32'd0);
            end
            if (req_valid) begin
                stale = 0;
                foreach (mq[i]) if (mq[i].ep != epoch) stale++;
                chk("req_while_draining", 32'(stale), 32'd0);
            end
            if (req_valid && req_ready) begin
                chk("req_addr", req_addr, exp_fetch);
                mq.push_back('{req_addr, epoch, cyc + lat});
                exp_fetch += 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_pops(input int n, input int budget, input string tag);
        int start;
        start = pops;
        for (int i = 0; i < budget && pops - start < n; i++) step();
        chk(tag, 32'(pops - start >= n), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        int p0;
        // Reset, then streaming with latency 1 and a ready consumer.
        out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        out_ready = 1'b1;
        chk_first = 1;
        mark = 1;
        repeat (12) step();
        chk("stream_first_pc", first_pc, RPC);
        p0 = pops;
        repeat (10) step();
        chk("steady_rate", 32'(pops - p0), 32'd10);

        // Backpressure: the queue fills and requests stop at 0xC.
        do_reset();
        out_ready = 1'b0;
        repeat (20) step();
        chk("bp_count", 32'(sb.size()), 32'd4);
        chk("bp_inflight", 32'(mq.size()), 32'd0);
        chk("bp_req_valid", 32'(req_valid), 32'd0);
        chk("bp_next_fetch", exp_fetch, 32'h10);
        out_ready = 1'b1;
        mark = 1;
        run_until_pops(4, 12, "bp_drain");
        chk("bp_drain_first_pc", first_pc, RPC);

        // Three requests outstanding at latency 3, then redirect to 0x100.
        do_reset();
        lat = 3;
        mem_stall = 1;
        rdy_lim = 3;
        repeat (5) step();
        chk("three_inflight", 32'(mq.size()), 32'd3);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        mem_stall = 0;
        rdy_lim = 99;
        mark = 1;
        run_until_pops(4, 40, "redirect_pops");
        chk("redirect_first_pc", first_pc, 32'h100);

        // Redirect coinciding with a response and a pop; unaligned target.
        do_reset();
        lat = 2;
        repeat (10) step();
        redirect = 1'b1;
        redirect_pc = 32'h203;
        step();
        redirect = 1'b0;
        chk("redir_same_rsp", 32'(last_rsp), 32'd1);
`ifndef FETCH_QUEUE_BYPASS_EN
        chk("redir_same_pop", 32'(last_ov), 32'd1);
`endif
        step();
        chk("empty_after_redirect", 32'(last_ov), 32'd0);
        mark = 1;
        run_until_pops(3, 30, "redir2_pops");
        chk("aligned_redirect_pc", first_pc, 32'h200);

        // Empty FIFO and a response for address 0 (data 0x00500093).
        do_reset();
        lat = 1;
        step();
        step();
        chk("rsp_cycle", 32'(last_rsp), 32'd1);
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("bypass_valid", 32'(last_ov), 32'd1);
        chk("bypass_inst", last_inst, 32'h0050_0093);
`else
        chk("no_bypass_valid", 32'(last_ov), 32'd0);
`endif
        run_until_pops(3, 10, "tail_pops");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
